// File: rtl/rrc_mac_scheduler.sv
// Sequencer for the time-shared polyphase RRC interpolator: symbol-history writes, tap/history addressing, MAC strobes.
// Latency tick->out_strobe: 2N(p)+2 cycles at phase 0, 2N(p)+1 otherwise; ticks arriving while busy are dropped with an overrun pulse.
module rrc_mac_scheduler #(
    parameter int NUM_TAPS   = 33,
    parameter int SPS        = 4,
    parameter int HIST_DEPTH = (NUM_TAPS + SPS - 1) / SPS,
    parameter int CA_W       = $clog2(NUM_TAPS),
    parameter int HA_W       = $clog2(HIST_DEPTH),
    parameter int PH_W       = (SPS > 1) ? $clog2(SPS) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic            flush,
    input  logic            sample_tick,
    input  logic            sym_valid,
    output logic            sym_ready,
    output logic            hist_we,
    output logic            hist_wzero,
    output logic [HA_W-1:0] hist_waddr,
    output logic [HA_W-1:0] hist_raddr,
    output logic [CA_W-1:0] coef_addr,
    output logic            mac_branch,
    output logic            mac_en,
    output logic            mac_first,
    output logic            mac_last,
    output logic            out_strobe,
    output logic [PH_W-1:0] phase,
    output logic            busy,
    output logic            underrun,
    output logic            overrun
);

    typedef enum logic [2:0] {
        S_FLUSH,
        S_IDLE,
        S_LOAD,
        S_MAC_I,
        S_MAC_Q,
        S_DONE
    } state_t;

    state_t          state;
    logic [CA_W-1:0] cnt;
    logic [HA_W-1:0] wptr;
    logic            flush_pend;
    logic [CA_W-1:0] last_k;

    // Index of the final tap for the current phase: ceil((NUM_TAPS-p)/SPS) - 1
    assign last_k = CA_W'((NUM_TAPS - 1 - int'(phase)) / SPS);

    function automatic logic [HA_W-1:0] hinc(input logic [HA_W-1:0] a);
        return (a == HA_W'(HIST_DEPTH - 1)) ? '0 : a + 1'b1;
    endfunction

    function automatic logic [HA_W-1:0] hdec(input logic [HA_W-1:0] a);
        return (a == '0) ? HA_W'(HIST_DEPTH - 1) : a - 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            wptr       <= '0;
            flush_pend <= 1'b1;   // forces the history clear on the first clock out of reset
            sym_ready  <= 1'b0;
            hist_we    <= 1'b0;
            hist_wzero <= 1'b0;
            hist_waddr <= '0;
            hist_raddr <= '0;
            coef_addr  <= '0;
            mac_branch <= 1'b0;
            mac_en     <= 1'b0;
            mac_first  <= 1'b0;
            mac_last   <= 1'b0;
            out_strobe <= 1'b0;
            phase      <= '0;
            busy       <= 1'b0;
            underrun   <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            sym_ready  <= 1'b0;
            hist_we    <= 1'b0;
            hist_wzero <= 1'b0;
            mac_en     <= 1'b0;
            mac_first  <= 1'b0;
            mac_last   <= 1'b0;
            out_strobe <= 1'b0;
            underrun   <= 1'b0;
            overrun    <= 1'b0;

            if (state != S_IDLE && state != S_FLUSH) begin
                if (flush)       flush_pend <= 1'b1;
                if (sample_tick) overrun    <= 1'b1;
            end

            case (state)
                S_FLUSH: begin
                    if (cnt == CA_W'(HIST_DEPTH - 1)) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        wptr  <= '0;
                        phase <= '0;
                    end else begin
                        cnt        <= cnt + 1'b1;
                        hist_we    <= 1'b1;
                        hist_wzero <= 1'b1;
                        hist_waddr <= HA_W'(cnt + 1'b1);
                    end
                end

                S_IDLE: begin
                    if (flush || flush_pend) begin
                        state      <= S_FLUSH;
                        busy       <= 1'b1;
                        cnt        <= '0;
                        flush_pend <= 1'b0;
                        hist_we    <= 1'b1;
                        hist_wzero <= 1'b1;
                        hist_waddr <= '0;
                    end else if (sample_tick && enable) begin
                        busy <= 1'b1;
                        if (phase == '0) begin
                            state      <= S_LOAD;
                            hist_we    <= 1'b1;
                            hist_waddr <= wptr;
                            sym_ready  <= sym_valid;
                            hist_wzero <= ~sym_valid;
                            underrun   <= ~sym_valid;
                            wptr       <= hinc(wptr);
                        end else begin
                            state      <= S_MAC_I;
                            cnt        <= '0;
                            mac_en     <= 1'b1;
                            mac_first  <= 1'b1;
                            mac_last   <= (last_k == '0);
                            mac_branch <= 1'b0;
                            coef_addr  <= CA_W'(phase);
                            hist_raddr <= hdec(wptr);
                        end
                    end
                end

                S_LOAD: begin
                    state      <= S_MAC_I;
                    cnt        <= '0;
                    mac_en     <= 1'b1;
                    mac_first  <= 1'b1;
                    mac_last   <= (last_k == '0);
                    mac_branch <= 1'b0;
                    coef_addr  <= CA_W'(phase);
                    hist_raddr <= hdec(wptr);
                end

                S_MAC_I, S_MAC_Q: begin
                    if (cnt == last_k) begin
                        if (state == S_MAC_I) begin
                            // Q branch replays the same taps over the same history window
                            state      <= S_MAC_Q;
                            cnt        <= '0;
                            mac_en     <= 1'b1;
                            mac_first  <= 1'b1;
                            mac_last   <= (last_k == '0);
                            mac_branch <= 1'b1;
                            coef_addr  <= CA_W'(phase);
                            hist_raddr <= hdec(wptr);
                        end else begin
                            state      <= S_DONE;
                            out_strobe <= 1'b1;
                        end
                    end else begin
                        cnt        <= cnt + 1'b1;
                        mac_en     <= 1'b1;
                        mac_last   <= ((cnt + 1'b1) == last_k);
                        coef_addr  <= coef_addr + CA_W'(SPS);
                        hist_raddr <= hdec(hist_raddr);
                    end
                end

                S_DONE: begin
                    phase <= (phase == PH_W'(SPS - 1)) ? '0 : phase + 1'b1;
                    if (flush || flush_pend) begin
                        state      <= S_FLUSH;
                        cnt        <= '0;
                        flush_pend <= 1'b0;
                        hist_we    <= 1'b1;
                        hist_wzero <= 1'b1;
                        hist_waddr <= '0;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rrc_mac_scheduler.sv
// Bench for rrc_mac_scheduler: queue-based cycle model checked every cycle, plus literal scenario checks.
`timescale 1ns/1ps
module tb_rrc_mac_scheduler;
    localparam int NT  = 33;
    localparam int SPS = 4;
    localparam int HD  = 9;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       enable = 1'b0, flush = 1'b0, sample_tick = 1'b0, sym_valid = 1'b0;
    logic       sym_ready, hist_we, hist_wzero, mac_branch, mac_en, mac_first, mac_last;
    logic       out_strobe, busy, underrun, overrun;
    logic [3:0] hist_waddr, hist_raddr;
    logic [5:0] coef_addr;
    logic [1:0] phase;

    rrc_mac_scheduler dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
        .sample_tick(sample_tick), .sym_valid(sym_valid), .sym_ready(sym_ready),
        .hist_we(hist_we), .hist_wzero(hist_wzero), .hist_waddr(hist_waddr),
        .hist_raddr(hist_raddr), .coef_addr(coef_addr), .mac_branch(mac_branch),
        .mac_en(mac_en), .mac_first(mac_first), .mac_last(mac_last),
        .out_strobe(out_strobe), .phase(phase), .busy(busy),
        .underrun(underrun), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: each sample is expanded into its list of output cycles
    localparam logic [2:0] K_IDLE = 0, K_FLUSH = 1, K_LOAD = 2, K_MAC = 3, K_DONE = 4;
    typedef struct packed {
        logic [2:0] kind;
        logic       busy, we, wzero, sready, en, first, last, branch, strobe, under;
        logic [3:0] waddr, raddr;
        logic [5:0] coef;
    } rec_t;

    rec_t cur;
    rec_t plan[$];
    int   mwptr, mphase;
    bit   fpend, exp_ov;

    task automatic plan_flush();
        rec_t r;
        for (int i = 0; i < HD; i++) begin
            r = '0; r.kind = K_FLUSH; r.busy = 1; r.we = 1; r.wzero = 1; r.waddr = 4'(i);
            plan.push_back(r);
        end
    endtask

    task automatic plan_sample(input bit v);
        rec_t r;
        int   n;
        n = (NT - mphase + SPS - 1) / SPS;
        if (mphase == 0) begin
            r = '0; r.kind = K_LOAD; r.busy = 1; r.we = 1; r.waddr = 4'(mwptr);
            r.wzero = !v; r.sready = v; r.under = !v;
            plan.push_back(r);
            mwptr = (mwptr + 1) % HD;
        end
        for (int b = 0; b < 2; b++)
            for (int k = 0; k < n; k++) begin
                r = '0; r.kind = K_MAC; r.busy = 1; r.en = 1; r.branch = b[0];
                r.first = (k == 0); r.last = (k == n - 1);
                r.coef  = 6'(mphase + k * SPS);
                r.raddr = 4'(((mwptr - 1 - k) % HD + HD) % HD);
                plan.push_back(r);
            end
        r = '0; r.kind = K_DONE; r.busy = 1; r.strobe = 1;
        plan.push_back(r);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur = '0; plan.delete(); mwptr = 0; mphase = 0; fpend = 1; exp_ov = 0;
        end else begin
            exp_ov = sample_tick && cur.busy && cur.kind != K_FLUSH;
            if (flush && cur.busy && cur.kind != K_FLUSH) fpend = 1;
            if (plan.size() == 0) begin
                if (cur.kind == K_DONE) mphase = (mphase + 1) % SPS;
                if (cur.kind == K_FLUSH) begin mwptr = 0; mphase = 0; end
                if ((cur.kind == K_IDLE || cur.kind == K_DONE) && (flush || fpend)) begin
                    fpend = 0;
                    plan_flush();
                end else if (cur.kind == K_IDLE && sample_tick && enable) begin
                    plan_sample(sym_valid);
                end
            end
            cur = (plan.size() > 0) ? plan.pop_front() : rec_t'('0);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_busy", busy, cur.busy);
            chk("m_we", hist_we, cur.we);
            chk("m_mac_en", mac_en, cur.en);
            chk("m_strobe", out_strobe, cur.strobe);
            chk("m_sym_ready", sym_ready, cur.sready);
            chk("m_underrun", underrun, cur.under);
            chk("m_overrun", overrun, exp_ov);
            chk("m_phase", phase, mphase);
            if (cur.we) begin
                chk("m_waddr", hist_waddr, cur.waddr);
                chk("m_wzero", hist_wzero, cur.wzero);
            end
            if (cur.en) begin
                chk("m_raddr", hist_raddr, cur.raddr);
                chk("m_coef", coef_addr, cur.coef);
                chk("m_first", mac_first, cur.first);
                chk("m_last", mac_last, cur.last);
                chk("m_branch", mac_branch, cur.branch);
            end
        end
    end

    // ---------------- directed scenarios with literal expectations
    int q_raddr[$], q_coef[$], q_first[$], q_last[$];
    int ld_we, ld_sr, ld_wz, ld_un, ld_wa;

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic flush_seq_check();
        for (int i = 0; i < HD; i++) begin
            step();
            chk("flush_we", hist_we, 1);
            chk("flush_wzero", hist_wzero, 1);
            chk("flush_waddr", hist_waddr, i);
        end
        step();
        chk("flush_end_busy", busy, 0);
        chk("flush_end_phase", phase, 0);
    endtask

    task automatic run_sample(output int lat);
        q_raddr.delete(); q_coef.delete(); q_first.delete(); q_last.delete();
        lat = -1;
        sample_tick = 1;
        for (int n = 1; n <= 40 && lat < 0; n++) begin
            step();
            sample_tick = 0;
            if (n == 1) begin
                ld_we = hist_we; ld_sr = sym_ready; ld_wz = hist_wzero;
                ld_un = underrun; ld_wa = hist_waddr;
            end
            if (mac_en && !mac_branch) begin
                q_raddr.push_back(hist_raddr); q_coef.push_back(coef_addr);
                q_first.push_back(mac_first);  q_last.push_back(mac_last);
            end
            if (out_strobe) lat = n;
        end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got %0d tests expected completion", tests);
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

    initial begin
        int lat, nstr, nov, nfl;
        int exp_raddr[9];
        exp_raddr = '{0, 8, 7, 6, 5, 4, 3, 2, 1};

        // 1: reset state and flush sequence
        repeat (3) step();
        chk("rst_busy", busy, 0);
        chk("rst_we", hist_we, 0);
        chk("rst_mac_en", mac_en, 0);
        chk("rst_phase", phase, 0);
        enable = 1;
        rst_n  = 1;
        flush_seq_check();

        // 2: phase-0 sample with symbol
        sym_valid = 1;
        run_sample(lat);
        chk("p0_latency", lat, 20);
        chk("p0_load_we", ld_we, 1);
        chk("p0_sym_ready", ld_sr, 1);
        chk("p0_load_waddr", ld_wa, 0);
        chk("p0_ntaps", q_coef.size(), 9);
        for (int k = 0; k < q_coef.size() && k < 9; k++) begin
            chk("p0_raddr", q_raddr[k], exp_raddr[k]);
            chk("p0_coef", q_coef[k], 4 * k);
            chk("p0_first", q_first[k], (k == 0) ? 1 : 0);
            chk("p0_last", q_last[k], (k == 8) ? 1 : 0);
        end
        chk("p0_phase_after", phase, 1);

        // 3: phase 1, no LOAD
        run_sample(lat);
        chk("p1_latency", lat, 17);
        chk("p1_no_load", ld_we, 0);
        chk("p1_ntaps", q_coef.size(), 8);
        for (int k = 0; k < q_coef.size() && k < 8; k++)
            chk("p1_coef", q_coef[k], 1 + 4 * k);
        chk("p1_phase_after", phase, 2);
        run_sample(lat);
        chk("p2_latency", lat, 17);
        run_sample(lat);
        chk("p3_latency", lat, 17);
        chk("wrap_phase", phase, 0);

        // 4: underrun at phase 0
        sym_valid = 0;
        run_sample(lat);
        chk("un_pulse", ld_un, 1);
        chk("un_wzero", ld_wz, 1);
        chk("un_sym_ready", ld_sr, 0);
        chk("un_waddr", ld_wa, 1);
        chk("un_latency", lat, 20);
        sym_valid = 1;

        // 5a: second tick 5 cycles after the first
        nstr = 0; nov = 0;
        sample_tick = 1;
        for (int n = 1; n <= 30; n++) begin
            step();
            sample_tick = (n == 5);
            nstr += out_strobe;
            nov  += overrun;
        end
        chk("ov_count", nov, 1);
        chk("ov_strobes", nstr, 1);
        chk("ov_phase", phase, 2);

        // 5b: flush mid-MAC is deferred to the end of the sample
        nstr = 0; nfl = 0;
        sample_tick = 1;
        for (int n = 1; n <= 40; n++) begin
            step();
            sample_tick = 0;
            flush = (n == 6);
            if (nstr > 0 && hist_we && hist_wzero) nfl++;
            nstr += out_strobe;
        end
        chk("fl_strobes", nstr, 1);
        chk("fl_cycles", nfl, 9);
        chk("fl_busy", busy, 0);
        chk("fl_phase", phase, 0);

        // tick with enable low is ignored
        enable = 0; sample_tick = 1;
        step(); sample_tick = 0;
        repeat (3) step();
        chk("dis_busy", busy, 0);
        enable = 1;

        // flush and tick together: flush wins, no overrun
        nov = 0;
        flush = 1; sample_tick = 1;
        step(); flush = 0; sample_tick = 0;
        chk("ft_wzero", hist_wzero, 1);
        for (int n = 0; n < 12; n++) begin
            step();
            nov += overrun;
        end
        chk("ft_overrun", nov, 0);
        chk("ft_busy", busy, 0);

        // 6: async reset during MAC_Q
        sample_tick = 1;
        step(); sample_tick = 0;
        repeat (14) step();
        chk("rq_in_macq", mac_branch, 1);
        #3 rst_n = 0;
        #1;
        chk("rq_busy", busy, 0);
        chk("rq_mac_en", mac_en, 0);
        chk("rq_branch", mac_branch, 0);
        chk("rq_coef", coef_addr, 0);
        chk("rq_raddr", hist_raddr, 0);
        repeat (2) step();
        rst_n = 1;
        flush_seq_check();
        run_sample(lat);
        chk("post_rst_latency", lat, 20);
        chk("post_rst_waddr", ld_wa, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
